// File: rtl/xor_checksum.sv
// Frame XOR checksum with ready/valid handshakes on both sides.
// Accumulates words until in_last, then holds the result until the consumer takes it.
module xor_checksum #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MAX_LEN    = 16,
    parameter bit          ODD_PARITY = 1'b0,
    localparam int unsigned CW        = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    ocount_q, ocount_d;
    logic             oerr_q, oerr_d;
    logic             accept;
    logic             frame_start;

    // In HOLD the next frame's first word may only enter when the result leaves.
    assign in_ready    = rst_n & ((state_q == HOLD) ? out_ready : 1'b1);
    assign accept      = in_valid & in_ready;
    assign frame_start = accept & (state_q != ACCUM);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        err_d    = err_q;
        sum_d    = sum_q;
        ocount_d = ocount_q;
        oerr_d   = oerr_q;

        if (frame_start) begin
            acc_d   = in_data;
            count_d = CW'(1);
            err_d   = 1'b0;
        end else if (accept) begin
            acc_d = acc_q ^ in_data;
            if (count_q == MAX_CNT) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end

        if (accept && in_last) begin
            state_d  = HOLD;
            sum_d    = acc_d;
            ocount_d = count_d;
            oerr_d   = err_d;
        end else if (accept) begin
            state_d = ACCUM;
        end else if ((state_q == HOLD && out_ready) || state_q == 2'd3) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            sum_q    <= '0;
            ocount_q <= '0;
            oerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            err_q    <= err_d;
            sum_q    <= sum_d;
            ocount_q <= ocount_d;
            oerr_q   <= oerr_d;
        end
    end

    assign out_valid  = (state_q == HOLD);
    assign out_sum    = sum_q;
    assign out_count  = ocount_q;
    assign out_err    = oerr_q;
    assign out_parity = (^sum_q) ^ ODD_PARITY;

endmodule

// File: tb/tb_xor_checksum.sv
// Bench for xor_checksum: two instances (short/even and long/odd) share one stimulus stream
// and are compared every cycle against a frame-level model.
module tb_xor_checksum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic       rdy0, rdy1, ov0, ov1, par0, par1, err0, err1;
    logic [7:0] sum0, sum1;
    logic [2:0] cnt0;
    logic [4:0] cnt1;

    xor_checksum #(.WIDTH(8), .MAX_LEN(4), .ODD_PARITY(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy0), .out_sum(sum0), .out_parity(par0), .out_count(cnt0), .out_err(err0),
        .out_valid(ov0), .out_ready(out_ready)
    );

    xor_checksum #(.WIDTH(8), .MAX_LEN(16), .ODD_PARITY(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy1), .out_sum(sum1), .out_parity(par1), .out_count(cnt1), .out_err(err1),
        .out_valid(ov1), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: words of the open frame, plus the last completed result.
    byte unsigned frame_q[$];
    bit           pending = 1'b0;
    logic [7:0]   last_sum = '0;
    int           last_len = 0;
    bit           m_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q.delete();
            pending  = 1'b0;
            last_sum = '0;
            last_len = 0;
        end else begin
            m_acc = in_valid && (!pending || out_ready);
            if (pending && out_ready) pending = 1'b0;
            if (m_acc) begin
                frame_q.push_back(in_data);
                if (in_last) begin
                    last_sum = '0;
                    foreach (frame_q[i]) last_sum ^= frame_q[i];
                    last_len = frame_q.size();
                    frame_q.delete();
                    pending = 1'b1;
                end
            end
        end
    end

    function automatic int exp_cnt(input int len, input int mx);
        return (len > mx) ? mx : len;
    endfunction

    function automatic logic exp_par(input logic [7:0] s, input logic odd);
        return logic'($countones(s) % 2) ^ odd;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("in_ready0_rst", rdy0, 0);
            chk("in_ready1_rst", rdy1, 0);
        end else begin
            chk("in_ready0", rdy0, pending ? out_ready : 1'b1);
            chk("in_ready1", rdy1, pending ? out_ready : 1'b1);
        end
        chk("out_valid0", ov0, pending);
        chk("out_valid1", ov1, pending);
        chk("out_sum0", sum0, last_sum);
        chk("out_sum1", sum1, last_sum);
        chk("out_count0", cnt0, exp_cnt(last_len, 4));
        chk("out_count1", cnt1, exp_cnt(last_len, 16));
        chk("out_err0", err0, last_len > 4);
        chk("out_err1", err1, last_len > 16);
        chk("out_parity0", par0, exp_par(last_sum, 1'b0));
        chk("out_parity1", par1, exp_par(last_sum, 1'b1));
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
    endtask

    int lp;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) cyc(0, 8'h00, 0, 0);
        rst_n = 1'b1;
        cyc(0, 8'h00, 0, 1);

        // Three-word frame, result visible one edge after the last word.
        cyc(1, 8'h0F, 0, 1);
        cyc(1, 8'hF0, 0, 1);
        cyc(1, 8'hAA, 1, 1);
        cyc(0, 8'h00, 0, 0);
        @(negedge clk);
        chk("lit_3w_valid", ov0, 1);
        chk("lit_3w_sum", sum0, 8'h55);
        chk("lit_3w_count", cnt0, 3);
        chk("lit_3w_err", err0, 0);
        chk("lit_3w_par_even", par0, 0);
        chk("lit_3w_par_odd", par1, 1);

        // Back-pressure, then take + new first word on the same edge.
        repeat (4) cyc(0, 8'h00, 0, 0);
        chk("lit_bp_ready", rdy0, 0);
        cyc(1, 8'h3C, 0, 1);
        cyc(1, 8'hC3, 1, 1);
        cyc(0, 8'h00, 0, 0);
        @(negedge clk);
        chk("lit_b2b_sum", sum0, 8'hFF);
        chk("lit_b2b_count", cnt0, 2);
        cyc(0, 8'h00, 0, 1);

        // Single word.
        cyc(1, 8'h81, 1, 1);
        cyc(0, 8'h00, 0, 0);
        @(negedge clk);
        chk("lit_1w_sum", sum1, 8'h81);
        chk("lit_1w_count", cnt1, 1);
        chk("lit_1w_par_odd", par1, 1);
        chk("lit_1w_par_even", par0, 0);
        cyc(0, 8'h00, 0, 1);

        // Overlong frame on the MAX_LEN=4 instance.
        for (int i = 0; i < 6; i++) cyc(1, 8'h01, i == 5, 1);
        cyc(0, 8'h00, 0, 0);
        @(negedge clk);
        chk("lit_ovf_sum", sum0, 8'h00);
        chk("lit_ovf_count", cnt0, 4);
        chk("lit_ovf_err", err0, 1);
        chk("lit_ovf_count16", cnt1, 6);
        chk("lit_ovf_err16", err1, 0);
        cyc(1, 8'h07, 1, 1);
        cyc(0, 8'h00, 0, 0);
        @(negedge clk);
        chk("lit_after_ovf_err", err0, 0);
        chk("lit_after_ovf_count", cnt0, 1);
        cyc(0, 8'h00, 0, 1);

        // Gaps, with in_last set on a non-valid cycle.
        cyc(1, 8'h11, 0, 1);
        cyc(0, 8'hFF, 1, 1);
        cyc(1, 8'h22, 0, 1);
        cyc(0, 8'hEE, 0, 1);
        cyc(1, 8'h44, 1, 1);
        cyc(0, 8'h00, 0, 0);
        @(negedge clk);
        chk("lit_gap_sum", sum0, 8'h77);
        chk("lit_gap_count", cnt0, 3);
        cyc(0, 8'h00, 0, 1);

        // Reset mid-frame discards it.
        cyc(1, 8'hA1, 0, 1);
        cyc(1, 8'hB2, 0, 1);
        cyc(0, 8'h00, 0, 1);
        rst_n = 1'b0;
        repeat (2) cyc(0, 8'h00, 0, 1);
        rst_n = 1'b1;
        cyc(0, 8'h00, 0, 1);
        chk("lit_rst_nvalid", ov0, 0);
        cyc(1, 8'h12, 1, 1);
        cyc(0, 8'h00, 0, 0);
        @(negedge clk);
        chk("lit_rst_valid", ov0, 1);
        chk("lit_rst_sum", sum0, 8'h12);
        chk("lit_rst_count", cnt0, 1);
        cyc(0, 8'h00, 0, 1);

        // Random traffic with varying frame lengths and rare reset pulses.
        lp = 4;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: lp = 1;
                    1: lp = 4;
                    default: lp = 20;
                endcase
            end
            cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, lp) == 0,
                $urandom_range(0, 2) != 0);
            rst_n = ($urandom_range(0, 599) != 0);
        end
        cyc(0, 8'h00, 0, 1);
        rst_n = 1'b1;
        repeat (2) cyc(0, 8'h00, 0, 1);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
